mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the core's single AXI4 memory master between two requesters: instruction fetch (read-only) and the exec stage (loads/stores). Each requester uses a simple req/ack handshake. The arbiter grants one requester at a time, drives single-beat AXI read or write transactions, and returns a 32-bit result. It extracts and places data lanes within the 512-bit AXI data bus.

Parameters:
FETCH_ID, 4'd0, arid/awid for fetch transactions
EXEC_ID, 4'd1, arid/awid for exec transactions
EXEC_FIRST, 1, tie-break winner on the first arbitration after reset (1 = exec)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
f_req, e_req  in  1 each  request; held high until matching ack
e_we  in  1  exec request is a write
e_byte  in  1  exec access is byte (else word)
f_addr, e_addr  in  31 each  byte address
e_wdata  in  32  store data (byte store uses [7:0])
f_ack, e_ack  out  1 each  one-cycle completion pulse
f_rdata, e_rdata  out  32 each  read result, valid while ack=1
e_err  out  1  AXI response was non-OKAY; valid while e_ack=1
araddr, arid, arsize  out  31/4/3  read address channel
arvalid / arready  out / in  1 each
rdata, rresp  in  512/2
rvalid / rready  in / out  1 each
awaddr, awid, awsize  out  31/4/3  write address channel
awvalid / awready  out / in  1 each
wdata, wstrb, wlast  out  512/64/1
wvalid / wready  out / in  1 each
bresp  in  2
bvalid / bready  in / out  1 each
(arlen/awlen=0, burst INCR, cache 0011, lock/prot/qos=0 are tied off at top level.)

Behaviour:
- Reset (async, immediate): state IDLE; all valid/ready outputs, acks, e_err, rdata outputs, wstrb, wlast = 0; addresses/ids = 0; last_grant set so that EXEC_FIRST decides the first tie.
- States: IDLE, RD (AR+R), WR (AW+W+B), ACK.
- IDLE: no req -> stay. Single req -> grant it. Both -> grant the one not granted last (round-robin). Granted inputs (addr, we, byte, wdata) are captured at the grant edge; later input changes are ignored.
- Grant read (fetch, or exec with e_we=0), edge N: from N+1, arvalid=1, rready=1, araddr=addr, arid=requester id, arsize=0 for byte else 2. arvalid drops on the arready edge. rready drops on the rvalid edge, where data and rresp are captured; then go to ACK. R may complete in the same cycle as AR.
- Grant write, edge N: from N+1, awvalid=wvalid=bready=1 and wlast=1. wdata = e_wdata[31:0] replicated 16x (word) or e_wdata[7:0] replicated 64x (byte). wstrb = 4'hf<<{addr[5:2],2'b00} (word) or 1<<addr[5:0] (byte). awvalid and wvalid drop independently on their ready edges. bvalid is accepted only after both have completed, or in the same cycle as the last of them; it drops bready and moves to ACK.
- Read lane extract: word = rdata[{addr[5:2],5'b0}+:32] (addr[1:0] ignored); byte = zero-extended rdata[{addr[5:0],3'b0}+:8].
- ACK: exactly one cycle; the granted ack=1, the matching rdata output holds the result, e_err = (resp!=0). Next edge -> IDLE. Minimum time from one ack to the next grant is 1 cycle.
- Non-granted ack never asserts. A req dropped mid-transaction does not abort it; the ack still pulses.
- Fetch requests are always reads; exec write requests never touch f_*.
- Reset mid-transaction: all AXI valids drop immediately and no ack is issued. The memory subsystem is reset by the same rst.

Test Plan:
- Fetch read: f_req=1, f_addr=0x44, rdata lane1=0xDEADBEEF, arready/rvalid 1 cycle after valid -> araddr=0x44, arid=0, arsize=2, f_ack pulses once with f_rdata=0xDEADBEEF.
- Exec byte load: e_addr=0x3F, rdata[511:504]=0x9A -> arsize=0, e_rdata=0x0000009A, e_err=0.
- Exec word store: e_addr=0x08, e_wdata=0x12345678, awready delayed 3 cycles, wready immediate -> wstrb=64'h0F00, wdata lane2=0x12345678, bready held until bvalid, e_ack one cycle later.
- Simultaneous f_req and e_req from reset (EXEC_FIRST=1), both held -> exec served first, then fetch; repeated contention alternates grants.
- bresp=2'b10 on an exec store -> e_err=1 during e_ack; rresp=2'b10 on fetch -> f_ack with no e_err change.
- rst asserted while arvalid=1 -> arvalid=0 without waiting for a clock edge, no ack; after release, a new f_req completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one AXI4 master between instruction fetch and the exec stage.
// Revision: 1.0 - single-beat read/write, round-robin grant, 512-bit lane placement.
`timescale 1ns/1ps
`default_nettype none

module mem_arbiter #(
    parameter logic [3:0] FETCH_ID   = 4'd0,
    parameter logic [3:0] EXEC_ID    = 4'd1,
    parameter bit         EXEC_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         f_req_i,
    input  logic         e_req_i,
    input  logic         e_we_i,
    input  logic         e_byte_i,
    input  logic [30:0]  f_addr_i,
    input  logic [30:0]  e_addr_i,
    input  logic [31:0]  e_wdata_i,
    output logic         f_ack_o,
    output logic         e_ack_o,
    output logic [31:0]  f_rdata_o,
    output logic [31:0]  e_rdata_o,
    output logic         e_err_o,
    output logic [30:0]  araddr_o,
    output logic [3:0]   arid_o,
    output logic [2:0]   arsize_o,
    output logic         arvalid_o,
    input  logic         arready_i,
    input  logic [511:0] rdata_i,
    input  logic [1:0]   rresp_i,
    input  logic         rvalid_i,
    output logic         rready_o,
    output logic [30:0]  awaddr_o,
    output logic [3:0]   awid_o,
    output logic [2:0]   awsize_o,
    output logic         awvalid_o,
    input  logic         awready_i,
    output logic [511:0] wdata_o,
    output logic [63:0]  wstrb_o,
    output logic         wlast_o,
    output logic         wvalid_o,
    input  logic         wready_i,
    input  logic [1:0]   bresp_i,
    input  logic         bvalid_i,
    output logic         bready_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_ACK  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic           last_exec_q, last_exec_d;
    logic           gnt_exec_q, gnt_exec_d;
    logic [30:0]    addr_q, addr_d;
    logic           byte_q, byte_d;
    logic [1:0]     resp_q, resp_d;
    logic [31:0]    f_rdata_q, f_rdata_d;
    logic [31:0]    e_rdata_q, e_rdata_d;
    logic           arvalid_q, arvalid_d;
    logic           rready_q, rready_d;
    logic [30:0]    araddr_q, araddr_d;
    logic [3:0]     arid_q, arid_d;
    logic [2:0]     arsize_q, arsize_d;
    logic           awvalid_q, awvalid_d;
    logic           wvalid_q, wvalid_d;
    logic           bready_q, bready_d;
    logic [30:0]    awaddr_q, awaddr_d;
    logic [3:0]     awid_q, awid_d;
    logic [2:0]     awsize_q, awsize_d;
    logic [511:0]   wdata_q, wdata_d;
    logic [63:0]    wstrb_q, wstrb_d;
    logic           wlast_q, wlast_d;

    // Exec wins when it is the only requester or when fetch was served last.
    logic           w_pick_exec;
    logic [30:0]    w_addr;
    logic           w_byte;
    logic           w_we;
    logic [8:0]     w_wsel;
    logic [8:0]     w_bsel;
    logic [31:0]    w_rd_res;
    logic           w_aw_ok;
    logic           w_w_ok;

    assign w_pick_exec = e_req_i && (!f_req_i || !last_exec_q);
    assign w_addr      = w_pick_exec ? e_addr_i : f_addr_i;
    assign w_byte      = w_pick_exec && e_byte_i;
    assign w_we        = w_pick_exec && e_we_i;
    assign w_wsel      = {addr_q[5:2], 5'b0};
    assign w_bsel      = {addr_q[5:0], 3'b0};
    assign w_rd_res    = byte_q ? {24'b0, rdata_i[w_bsel +: 8]} : rdata_i[w_wsel +: 32];
    assign w_aw_ok     = !awvalid_q || awready_i;
    assign w_w_ok      = !wvalid_q || wready_i;

    always_comb begin
        state_d     = state_q;
        last_exec_d = last_exec_q;
        gnt_exec_d  = gnt_exec_q;
        addr_d      = addr_q;
        byte_d      = byte_q;
        resp_d      = resp_q;
        f_rdata_d   = f_rdata_q;
        e_rdata_d   = e_rdata_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        araddr_d    = araddr_q;
        arid_d      = arid_q;
        arsize_d    = arsize_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        awaddr_d    = awaddr_q;
        awid_d      = awid_q;
        awsize_d    = awsize_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        case (state_q)
            S_IDLE: begin
                if (f_req_i || e_req_i) begin
                    gnt_exec_d  = w_pick_exec;
                    last_exec_d = w_pick_exec;
                    addr_d      = w_addr;
                    byte_d      = w_byte;
                    if (w_we) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        awaddr_d  = w_addr;
                        awid_d    = EXEC_ID;
                        awsize_d  = w_byte ? 3'd0 : 3'd2;
                        wdata_d   = w_byte ? {64{e_wdata_i[7:0]}} : {16{e_wdata_i}};
                        wstrb_d   = w_byte ? (64'd1 << w_addr[5:0])
                                           : (64'hf << {w_addr[5:2], 2'b00});
                    end else begin
                        state_d   = S_RD;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        araddr_d  = w_addr;
                        arid_d    = w_pick_exec ? EXEC_ID : FETCH_ID;
                        arsize_d  = w_byte ? 3'd0 : 3'd2;
                    end
                end
            end
            S_RD: begin
                if (arready_i) begin
                    arvalid_d = 1'b0;
                end
                if (rvalid_i && rready_q) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b0;
                    resp_d    = rresp_i;
                    state_d   = S_ACK;
                    if (gnt_exec_q) begin
                        e_rdata_d = w_rd_res;
                    end else begin
                        f_rdata_d = w_rd_res;
                    end
                end
            end
            S_WR: begin
                if (awready_i) begin
                    awvalid_d = 1'b0;
                end
                if (wready_i) begin
                    wvalid_d = 1'b0;
                end
                // A response is only meaningful once both AW and W have been taken.
                if (bvalid_i && w_aw_ok && w_w_ok) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    resp_d    = bresp_i;
                    state_d   = S_ACK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        wlast_d = wvalid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_exec_q <= !EXEC_FIRST;
            gnt_exec_q  <= 1'b0;
            addr_q      <= '0;
            byte_q      <= 1'b0;
            resp_q      <= '0;
            f_rdata_q   <= '0;
            e_rdata_q   <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            araddr_q    <= '0;
            arid_q      <= '0;
            arsize_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            awaddr_q    <= '0;
            awid_q      <= '0;
            awsize_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_exec_q <= last_exec_d;
            gnt_exec_q  <= gnt_exec_d;
            addr_q      <= addr_d;
            byte_q      <= byte_d;
            resp_q      <= resp_d;
            f_rdata_q   <= f_rdata_d;
            e_rdata_q   <= e_rdata_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            araddr_q    <= araddr_d;
            arid_q      <= arid_d;
            arsize_q    <= arsize_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            awaddr_q    <= awaddr_d;
            awid_q      <= awid_d;
            awsize_q    <= awsize_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wlast_q     <= wlast_d;
        end
    end

    assign f_ack_o   = (state_q == S_ACK) && !gnt_exec_q;
    assign e_ack_o   = (state_q == S_ACK) && gnt_exec_q;
    assign e_err_o   = e_ack_o && (resp_q != 2'b00);
    assign f_rdata_o = f_rdata_q;
    assign e_rdata_o = e_rdata_q;
    assign araddr_o  = araddr_q;
    assign arid_o    = arid_q;
    assign arsize_o  = arsize_q;
    assign arvalid_o = arvalid_q;
    assign rready_o  = rready_q;
    assign awaddr_o  = awaddr_q;
    assign awid_o    = awid_q;
    assign awsize_o  = awsize_q;
    assign awvalid_o = awvalid_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign wlast_o   = wlast_q;
    assign wvalid_o  = wvalid_q;
    assign bready_o  = bready_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a hand-driven AXI responder.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         f_req, e_req, e_we, e_byte;
    logic [30:0]  f_addr, e_addr;
    logic [31:0]  e_wdata;
    logic         f_ack, e_ack, e_err;
    logic [31:0]  f_rdata, e_rdata;
    logic [30:0]  araddr, awaddr;
    logic [3:0]   arid, awid;
    logic [2:0]   arsize, awsize;
    logic         arvalid, arready, rvalid, rready;
    logic [511:0] rdata, wdata;
    logic [1:0]   rresp, bresp;
    logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [63:0]  wstrb;

    int n_cmp = 0;
    int n_bad = 0;

    logic [30:0]  s_araddr;
    logic [3:0]   s_arid;
    logic [2:0]   s_arsize;
    logic [511:0] pat;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .f_req_i(f_req), .e_req_i(e_req), .e_we_i(e_we), .e_byte_i(e_byte),
        .f_addr_i(f_addr), .e_addr_i(e_addr), .e_wdata_i(e_wdata),
        .f_ack_o(f_ack), .e_ack_o(e_ack), .f_rdata_o(f_rdata), .e_rdata_o(e_rdata),
        .e_err_o(e_err),
        .araddr_o(araddr), .arid_o(arid), .arsize_o(arsize),
        .arvalid_o(arvalid), .arready_i(arready),
        .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(rready),
        .awaddr_o(awaddr), .awid_o(awid), .awsize_o(awsize),
        .awvalid_o(awvalid), .awready_i(awready),
        .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast),
        .wvalid_o(wvalid), .wready_i(wready),
        .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge where the ack should be visible.
    task automatic rd_serve(input int dly, input logic [511:0] data, input logic [1:0] resp);
        int n = 0;
        while (!arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ar_seen", 64'(arvalid), 64'd1);
        s_araddr = araddr;
        s_arid   = arid;
        s_arsize = arsize;
        repeat (dly) @(negedge clk);
        chk("rready_held", 64'(rready), 64'd1);
        arready = 1'b1;
        rvalid  = 1'b1;
        rdata   = data;
        rresp   = resp;
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b0;
    endtask

    // W accepted as soon as offered, AW after aw_dly cycles, B one cycle after both.
    task automatic wr_serve(input int aw_dly, input logic [1:0] resp);
        int n = 0;
        while (!awvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("aw_seen", 64'(awvalid), 64'd1);
        chk("wlast", 64'(wlast), 64'd1);
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            wready  = wvalid;
            awready = awvalid && (n >= aw_dly);
            @(negedge clk);
            n++;
        end
        wready  = 1'b0;
        awready = 1'b0;
        chk("aw_w_done", 64'({awvalid, wvalid}), 64'd0);
        chk("bready_held", 64'(bready), 64'd1);
        bvalid = 1'b1;
        bresp  = resp;
        @(negedge clk);
        bvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        f_req = 0; e_req = 0; e_we = 0; e_byte = 0;
        f_addr = '0; e_addr = '0; e_wdata = '0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        awready = 0; wready = 0; bresp = '0; bvalid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valids", 64'({arvalid, rready, awvalid, wvalid, bready, wlast}), 64'd0);
        chk("rst_acks", 64'({f_ack, e_ack, e_err}), 64'd0);
        chk("rst_wstrb", wstrb, 64'd0);
        chk("rst_rdata", {f_rdata, e_rdata}, 64'd0);
        rst = 1'b0;

        // Contention from reset: exec first, then alternating.
        f_req = 1; e_req = 1; e_we = 0; e_byte = 0;
        f_addr = 31'h20; e_addr = 31'h10;
        for (int k = 0; k < 4; k++) begin
            rd_serve(0, {16{32'h1111_0000 + 32'(k)}}, 2'b00);
            chk("tie_arid", 64'(s_arid), (k % 2 == 0) ? 64'd1 : 64'd0);
            chk("tie_eack", 64'(e_ack), (k % 2 == 0) ? 64'd1 : 64'd0);
            chk("tie_fack", 64'(f_ack), (k % 2 == 0) ? 64'd0 : 64'd1);
            if (k == 3) begin
                f_req = 0;
                e_req = 0;
            end
        end
        @(negedge clk);
        chk("tie_ack_gone", 64'({f_ack, e_ack}), 64'd0);

        // Fetch word read; address change after grant must not leak.
        f_req = 1; f_addr = 31'h44;
        @(negedge clk);
        f_addr = 31'h80;
        pat = '0;
        pat[63:32] = 32'hDEADBEEF;
        rd_serve(1, pat, 2'b00);
        chk("f_araddr", 64'(s_araddr), 64'h44);
        chk("f_arid", 64'(s_arid), 64'd0);
        chk("f_arsize", 64'(s_arsize), 64'd2);
        chk("f_ack", 64'(f_ack), 64'd1);
        chk("f_rdata", 64'(f_rdata), 64'hDEADBEEF);
        chk("f_no_eack", 64'(e_ack), 64'd0);
        f_req = 0;
        @(negedge clk);
        chk("f_ack_once", 64'(f_ack), 64'd0);

        // Exec byte load from the top byte of the bus.
        e_req = 1; e_we = 0; e_byte = 1; e_addr = 31'h3F;
        pat = {8'h9A, {63{8'h55}}};
        rd_serve(0, pat, 2'b00);
        chk("b_arsize", 64'(s_arsize), 64'd0);
        chk("b_arid", 64'(s_arid), 64'd1);
        chk("b_eack", 64'(e_ack), 64'd1);
        chk("b_erdata", 64'(e_rdata), 64'h9A);
        chk("b_eerr", 64'(e_err), 64'd0);
        e_req = 0;
        @(negedge clk);

        // Exec word store with a slow AW channel.
        e_req = 1; e_we = 1; e_byte = 0; e_addr = 31'h08; e_wdata = 32'h12345678;
        @(negedge clk);
        chk("w_awaddr", 64'(awaddr), 64'h08);
        chk("w_awid", 64'(awid), 64'd1);
        chk("w_awsize", 64'(awsize), 64'd2);
        chk("w_wstrb", wstrb, 64'h0F00);
        chk("w_wlane2", 64'(wdata[95:64]), 64'h12345678);
        chk("w_wlane15", 64'(wdata[511:480]), 64'h12345678);
        wr_serve(3, 2'b00);
        chk("w_eack", 64'(e_ack), 64'd1);
        chk("w_eerr", 64'(e_err), 64'd0);
        chk("w_no_fack", 64'(f_ack), 64'd0);
        e_req = 0;
        @(negedge clk);
        chk("w_eack_once", 64'(e_ack), 64'd0);

        // Exec byte store with an error response.
        e_req = 1; e_we = 1; e_byte = 1; e_addr = 31'h05; e_wdata = 32'hFFFF_FFAB;
        @(negedge clk);
        chk("bs_wstrb", wstrb, 64'h20);
        chk("bs_awsize", 64'(awsize), 64'd0);
        chk("bs_wdata", wdata[511:448], {8{8'hAB}});
        wr_serve(0, 2'b10);
        chk("bs_eack", 64'(e_ack), 64'd1);
        chk("bs_eerr", 64'(e_err), 64'd1);
        e_req = 0;
        @(negedge clk);

        // Fetch read with an error response leaves e_err alone.
        f_req = 1; f_addr = 31'h0;
        pat = {16{32'hCAFE_0001}};
        rd_serve(0, pat, 2'b10);
        chk("fe_fack", 64'(f_ack), 64'd1);
        chk("fe_rdata", 64'(f_rdata), 64'hCAFE0001);
        chk("fe_eerr", 64'(e_err), 64'd0);
        f_req = 0;
        @(negedge clk);

        // Asynchronous reset with AR outstanding.
        f_req = 1; f_addr = 31'h100;
        @(negedge clk);
        chk("r_arvalid_up", 64'(arvalid), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("r_arvalid_drop", 64'({arvalid, rready}), 64'd0);
        f_req = 0;
        @(negedge clk);
        chk("r_no_ack", 64'({f_ack, e_ack}), 64'd0);
        rst = 1'b0;
        f_req = 1; f_addr = 31'h4;
        pat = '0;
        pat[63:32] = 32'h0BAD_F00D;
        rd_serve(0, pat, 2'b00);
        chk("r_after_araddr", 64'(s_araddr), 64'h4);
        chk("r_after_fack", 64'(f_ack), 64'd1);
        chk("r_after_rdata", 64'(f_rdata), 64'h0BADF00D);
        f_req = 0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
